// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM states, default timing, counter sizing helpers.
// Latency: none; declarations only.
// Backpressure: none.
package key_pkg;

   // Default timing, chosen for a 50 MHz board clock.
   localparam int DEF_N_KEYS          = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
   localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
   localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

   // Per-channel debounce state.
   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_state_t;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Timing values below one cycle are treated as one cycle.
   function automatic int at_least_one(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, auto-repeat timer.
// Latency: press/release pulse DEBOUNCE_CYCLES+2 cycles after a clean raw edge; pulses are registered.
// Backpressure: none; the raw pin is sampled every cycle and pulses are not held.
module key_channel
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   input  logic repeat_en,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_repeat
);

   localparam int DB_TGT = at_least_one(DEBOUNCE_CYCLES);
   localparam int RD_TGT = at_least_one(REPEAT_DELAY);
   localparam int RP_TGT = at_least_one(REPEAT_PERIOD);
   localparam int RT_MAX = max2(RD_TGT, RP_TGT);

   localparam int DB_W = cnt_width(DB_TGT);
   localparam int RT_W = cnt_width(RT_MAX);

   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [DB_W-1:0] DB_SAT  = DB_W'(DB_TGT);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_TGT - 1);

   localparam logic [RT_W-1:0] RT_ONE  = RT_W'(1);
   localparam logic [RT_W-1:0] RT_SAT  = RT_W'(RT_MAX);
   localparam logic [RT_W-1:0] RD_LAST = RT_W'(RD_TGT - 1);
   localparam logic [RT_W-1:0] RP_LAST = RT_W'(RP_TGT - 1);

   // Synchronizer flops carry the raw active-low level.
   logic            sync_meta;
   logic            sync_q;
   logic            key_in;

   key_state_t      state;

   // db_cnt = number of consecutive samples already seen at the new level.
   logic [DB_W-1:0] db_cnt;
   logic [DB_W-1:0] db_inc;
   logic            db_done;

   // rpt_cnt = enabled held cycles since the last repeat event (or press).
   logic [RT_W-1:0] rpt_cnt;
   logic [RT_W-1:0] rpt_inc;
   logic [RT_W-1:0] rpt_last;
   logic            rpt_first;

   logic            held;
   logic            release_now;

   // Bring the asynchronous pin into the clk domain; reset parks it at "not pressed".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b1;
         sync_q    <= 1'b1;
      end else begin
         sync_meta <= key_n;
         sync_q    <= sync_meta;
      end
   end

   assign key_in = ~sync_q;

   // Counters stop at their ceiling instead of wrapping.
   assign db_inc  = (db_cnt == DB_SAT) ? db_cnt : db_cnt + DB_ONE;
   assign rpt_inc = (rpt_cnt == RT_SAT) ? rpt_cnt : rpt_cnt + RT_ONE;

   // The current sample completes a full stable run. db_cnt is zero in
   // RELEASED/HELD, so there this is only true for a one-cycle debounce.
   assign db_done = (db_cnt >= DB_LAST);

   assign held        = (state == ST_HELD) || (state == ST_RELEASE_WAIT);
   assign release_now = held && !key_in && db_done;
   assign rpt_last    = rpt_first ? RD_LAST : RP_LAST;

   // Debounce FSM; level and press/release pulses are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RELEASED;
         db_cnt      <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         case (state)
            ST_RELEASED: begin
               db_cnt <= '0;
               if (key_in) begin
                  if (db_done) begin
                     state     <= ST_HELD;
                     key_level <= 1'b1;
                     key_press <= 1'b1;
                  end else begin
                     state  <= ST_PRESS_WAIT;
                     db_cnt <= DB_ONE;
                  end
               end
            end
            ST_PRESS_WAIT: begin
               if (!key_in) begin
                  // Bounce: start over from the released side.
                  state  <= ST_RELEASED;
                  db_cnt <= '0;
               end else if (db_done) begin
                  state     <= ST_HELD;
                  db_cnt    <= '0;
                  key_level <= 1'b1;
                  key_press <= 1'b1;
               end else begin
                  db_cnt <= db_inc;
               end
            end
            ST_HELD: begin
               db_cnt <= '0;
               if (!key_in) begin
                  if (db_done) begin
                     state       <= ST_RELEASED;
                     key_level   <= 1'b0;
                     key_release <= 1'b1;
                  end else begin
                     state  <= ST_RELEASE_WAIT;
                     db_cnt <= DB_ONE;
                  end
               end
            end
            ST_RELEASE_WAIT: begin
               if (key_in) begin
                  // Release glitch: back to HELD silently, repeat timer untouched.
                  state  <= ST_HELD;
                  db_cnt <= '0;
               end else if (db_done) begin
                  state       <= ST_RELEASED;
                  db_cnt      <= '0;
                  key_level   <= 1'b0;
                  key_release <= 1'b1;
               end else begin
                  db_cnt <= db_inc;
               end
            end
            default: begin
               state  <= ST_RELEASED;
               db_cnt <= '0;
            end
         endcase
      end
   end

   // Auto-repeat timer: runs only while held and enabled, first interval
   // REPEAT_DELAY then REPEAT_PERIOD; a release in the same cycle suppresses the tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_cnt    <= '0;
         rpt_first  <= 1'b1;
         key_repeat <= 1'b0;
      end else begin
         key_repeat <= 1'b0;
         if (!held || !repeat_en) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
         end else if (rpt_cnt >= rpt_last) begin
            rpt_cnt    <= '0;
            rpt_first  <= 1'b0;
            key_repeat <= !release_now;
         end else begin
            rpt_cnt <= rpt_inc;
         end
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low push buttons into debounced levels, press/release pulses and auto-repeat ticks.
// Latency: DEBOUNCE_CYCLES+2 cycles from a clean raw edge to the registered press/release pulse.
// Backpressure: none; channels are independent and outputs are single-cycle pulses or levels.
module key_conditioner
   import key_pkg::*;
#(
   parameter int N_KEYS          = DEF_N_KEYS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_n,
   input  logic              repeat_en,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat,
   output logic              any_pressed
);

   // One fully independent channel per button; no arbitration between them.
   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .key_n       (key_n[g]),
         .repeat_en   (repeat_en),
         .key_level   (key_level[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g]),
         .key_repeat  (key_repeat[g])
      );
   end

   assign any_pressed = |key_level;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed button scenarios, literal per-cycle expectations and a window-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_conditioner;

   localparam int N    = 2;
   localparam int DB   = 4;
   localparam int RD   = 10;
   localparam int RP   = 3;
   localparam int MAXH = 8192;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] key_n;
   logic         repeat_en;
   logic [N-1:0] key_level;
   logic [N-1:0] key_press;
   logic [N-1:0] key_release;
   logic [N-1:0] key_repeat;
   logic         any_pressed;

   int errors = 0;
   int checks = 0;

   key_conditioner #(
      .N_KEYS          (N),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n),
      .repeat_en   (repeat_en),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_repeat  (key_repeat),
      .any_pressed (any_pressed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Rules: the synced sample at edge n is the pressed state of the pin at
   // edge n-2; the level flips when the last DB samples all disagree with it;
   // repeat ticks on the RD-th, RD+RP-th, ... consecutive enabled held edge,
   // unless that edge is the release.
   logic [N-1:0] raw_hist [MAXH];
   int           edge_n;
   int           rep_run [N];
   logic [N-1:0] m_level, m_press, m_release, m_repeat;

   function automatic logic synced(input int m, input int k);
      if (m - 2 < 1) return 1'b0;
      return raw_hist[m-2][k];
   endfunction

   initial begin
      edge_n    = 0;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_repeat  = '0;
      for (int k = 0; k < N; k++) rep_run[k] = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            edge_n    = 0;
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            m_repeat  = '0;
            for (int k = 0; k < N; k++) rep_run[k] = 0;
         end else begin
            edge_n++;
            if (edge_n >= MAXH) begin
               $display("FAIL model_history: edge %0d exceeds %0d", edge_n, MAXH);
               $fatal(1);
            end
            raw_hist[edge_n] = ~key_n;
            for (int k = 0; k < N; k++) begin
               logic all1, all0, fire;
               all1 = 1'b1;
               all0 = 1'b1;
               for (int j = 0; j < DB; j++) begin
                  all1 = all1 & synced(edge_n - j, k);
                  all0 = all0 & ~synced(edge_n - j, k);
               end
               m_press[k]   = !m_level[k] && all1;
               m_release[k] = m_level[k] && all0;
               if (m_level[k] && repeat_en) rep_run[k]++;
               else rep_run[k] = 0;
               fire = (rep_run[k] == RD) || (rep_run[k] > RD && (rep_run[k] - RD) % RP == 0);
               m_repeat[k] = fire && !m_release[k];
               if (m_press[k])   m_level[k] = 1'b1;
               if (m_release[k]) m_level[k] = 1'b0;
            end
         end
      end
   end

   // Every cycle, compare all outputs to the model, just after the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         check("cmp_level",   8'(key_level),   8'(m_level));
         check("cmp_press",   8'(key_press),   8'(m_press));
         check("cmp_release", 8'(key_release), 8'(m_release));
         check("cmp_repeat",  8'(key_repeat),  8'(m_repeat));
         check("cmp_any",     8'(any_pressed), 8'(|m_level));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_level"},   8'(key_level),   8'd0);
      check({name, "_press"},   8'(key_press),   8'd0);
      check({name, "_release"}, 8'(key_release), 8'd0);
      check({name, "_repeat"},  8'(key_repeat),  8'd0);
      check({name, "_any"},     8'(any_pressed), 8'd0);
   endtask

   logic bounce [5];

   initial begin
      rst       = 1'b1;
      key_n     = '1;
      repeat_en = 1'b0;
      bounce    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset state.
      repeat (2) begin
         @(negedge clk);
         check_all_zero("reset");
      end
      rst = 1'b0;
      idle(4);

      // Clean press then release of key 0: pulses at relative cycle 6.
      @(negedge clk);
      key_n[0] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check("clean_press", 8'(key_press[0]), 8'(c == 6));
         check("clean_level", 8'(key_level[0]), 8'(c >= 6));
      end
      key_n[0] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check("clean_release", 8'(key_release[0]), 8'(c == 6));
         check("clean_level_fall", 8'(key_level[0]), 8'(c < 6));
      end
      idle(3);

      // Bouncy press: last edge at cycle 4, single press at cycle 10.
      @(negedge clk);
      key_n[0] = bounce[0];
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         check("bounce_press", 8'(key_press[0]), 8'(c == 10));
         check("bounce_release", 8'(key_release[0]), 8'd0);
         if (c <= 4) key_n[0] = bounce[c];
      end
      key_n[0] = 1'b1;
      idle(12);

      // Auto-repeat while held for 30 cycles after the press (press at 6).
      repeat_en = 1'b1;
      idle(2);
      @(negedge clk);
      key_n[0] = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         check("rpt_press", 8'(key_press[0]), 8'(c == 6));
         check("rpt_tick", 8'(key_repeat[0]), 8'(c >= 16 && (c - 16) % 3 == 0));
      end
      key_n[0] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check("rpt_release", 8'(key_release[0]), 8'(c == 6));
      end
      idle(4);

      // Disable at press+14, re-enable at press+18; release coincides with a tick.
      @(negedge clk);
      key_n[0] = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         check("dis_tick", 8'(key_repeat[0]),
               8'(c == 16 || c == 19 || c == 34 || c == 37 || c == 40));
         if (c == 20) repeat_en = 1'b0;
         if (c == 24) repeat_en = 1'b1;
      end
      key_n[0] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check("dis_release", 8'(key_release[0]), 8'(c == 6));
         check("dis_release_wins", 8'(key_repeat[0]), 8'(c == 3));
      end
      idle(4);

      // Two-cycle release glitch while held: no release, cadence unchanged.
      @(negedge clk);
      key_n[0] = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         check("glitch_press", 8'(key_press[0]), 8'(c == 6));
         check("glitch_release", 8'(key_release[0]), 8'd0);
         check("glitch_tick", 8'(key_repeat[0]), 8'(c == 16 || c == 19 || c == 22 || c == 25));
         if (c == 12) key_n[0] = 1'b1;
         if (c == 14) key_n[0] = 1'b0;
      end
      key_n[0] = 1'b1;
      idle(12);

      // Both keys together, then key 1 alone released.
      repeat_en = 1'b0;
      @(negedge clk);
      key_n = 2'b00;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check("dual_press", 8'(key_press), (c == 6) ? 8'b11 : 8'b00);
      end
      key_n = 2'b10;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check("dual_release", 8'(key_release), (c == 6) ? 8'b10 : 8'b00);
         check("dual_level", 8'(key_level), (c >= 6) ? 8'b01 : 8'b11);
         check("dual_no_press", 8'(key_press), 8'd0);
      end
      key_n = 2'b11;
      idle(12);

      // Reset while key 0 is in PRESS_WAIT; press must come 6 cycles after reset falls.
      @(negedge clk);
      key_n[0] = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 3) check("rst_prewait_press", 8'(key_press[0]), 8'd0);
         if (c >= 4) check_all_zero("rst_hold");
         if (c == 3) rst = 1'b1;
         if (c == 5) rst = 1'b0;
      end
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         check("rst_press", 8'(key_press[0]), 8'(c == 6));
         check("rst_level", 8'(key_level[0]), 8'(c >= 6));
      end
      key_n[0] = 1'b1;
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
